// File: rtl/rv32i_pkg.sv
// Shared RV32I core constants: datapath width and default memory sizing,
// used by the data memory, instruction memory and core top.
package rv32i_pkg;

  localparam int XLEN       = 32;
  localparam int DMEM_DEPTH = 64;

endpackage : rv32i_pkg

// File: rtl/data_memory.sv
// Word-organised data memory: combinational read, rising-edge full-word write,
// asynchronous active-low clear of the whole array.
module data_memory
  import rv32i_pkg::*;
#(
  parameter int DEPTH = DMEM_DEPTH
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] wd,
  input  logic            we,
  output logic [XLEN-1:0] rd
);

  localparam int AW = $clog2(DEPTH);

  generate
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("data_memory: DEPTH must be a power of two and at least 2");
    end
  endgenerate

  logic [XLEN-1:0] mem [DEPTH];
  logic [AW-1:0]   idx;

  // Byte offset and upper address bits are ignored: misaligned accesses hit the
  // containing word and addresses alias modulo DEPTH*4 bytes.
  assign idx = a[AW+1:2];

  logic unused_addr_bits;
  assign unused_addr_bits = ^{a[1:0], a[XLEN-1:AW+2]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[idx] <= wd;
    end
  end

  // No write-through bypass: a same-address write shows up only after the edge.
  assign rd = mem[idx];

endmodule : data_memory

// File: tb/tb_data_memory.sv
// Directed bench for data_memory: expected read values are queued as each
// stimulus step is driven and popped when rd is sampled.
module tb_data_memory;

  logic        clk;
  logic        rst_n;
  logic [31:0] a;
  logic [31:0] wd;
  logic        we;
  logic [31:0] rd;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   vectors;
  int   miscompares;

  data_memory #(.DEPTH(64)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .wd    (wd),
    .we    (we),
    .rd    (rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push_exp(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    exp_q.push_back(e);
  endtask

  task automatic check_rd();
    exp_t e;
    if (exp_q.size() == 0) begin
      miscompares++;
      $error("FAIL scoreboard_empty: no expected value queued, rd=%h", rd);
    end else begin
      e = exp_q.pop_front();
      vectors++;
      assert (rd === e.val) else begin
        miscompares++;
        $error("FAIL %s: rd=%h expected %h", e.tag, rd, e.val);
      end
    end
  endtask

  // Drive an address, let the combinational read settle, then compare.
  task automatic read_step(input string tag, input logic [31:0] addr, input logic [31:0] val);
    a = addr;
    push_exp(tag, val);
    #1;
    check_rd();
  endtask

  task automatic write_word(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    a  = addr;
    wd = data;
    we = 1'b1;
    @(posedge clk);
    #1;
    we = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n = 1'b0;
    we    = 1'b0;
    a     = '0;
    wd    = '0;

    #2;
    read_step("in_reset_a0", 32'd0, 32'h0);

    @(negedge clk);
    rst_n = 1'b1;
    read_step("reset_a0",   32'd0,   32'h0);
    read_step("reset_a4",   32'd4,   32'h0);
    read_step("reset_a8",   32'd8,   32'h0);
    read_step("reset_a252", 32'd252, 32'h0);

    write_word(32'd4, 32'hF00AA00F);
    read_step("wr_readback_a4", 32'd4, 32'hF00AA00F);
    read_step("wr_neighbor_a8", 32'd8, 32'h0);

    @(negedge clk);
    a  = 32'd8;
    wd = 32'hDEADBEEF;
    we = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    read_step("inhibit_a8", 32'd8, 32'h0);
    read_step("inhibit_a4", 32'd4, 32'hF00AA00F);

    write_word(32'd12, 32'h12345678);
    read_step("align_a12",  32'd12,  32'h12345678);
    read_step("misalign_a13", 32'd13, 32'h12345678);
    read_step("misalign_a15", 32'd15, 32'h12345678);
    read_step("alias_a268", 32'd268, 32'h12345678);
    read_step("alias_hi",   32'h8000_000C, 32'h12345678);

    write_word(32'd16, 32'h1);
    @(negedge clk);
    a  = 32'd16;
    wd = 32'h2;
    we = 1'b1;
    push_exp("rdw_before_edge", 32'h1);
    #1;
    check_rd();
    @(posedge clk);
    push_exp("rdw_after_edge", 32'h2);
    #1;
    check_rd();
    we = 1'b0;

    // Assert reset between edges and expect rd to clear without a clock.
    @(negedge clk);
    read_step("pre_reset_a4", 32'd4, 32'hF00AA00F);
    #1;
    rst_n = 1'b0;
    push_exp("async_clear_a4", 32'h0);
    #1;
    check_rd();
    read_step("async_clear_a16", 32'd16, 32'h0);

    @(negedge clk);
    a  = 32'd4;
    wd = 32'h55AA55AA;
    we = 1'b1;
    @(posedge clk);
    #1;
    read_step("write_during_reset", 32'd4, 32'h0);
    @(negedge clk);
    we    = 1'b0;
    rst_n = 1'b1;
    read_step("after_release_a4", 32'd4, 32'h0);

    write_word(32'd20, 32'hCAFEF00D);
    read_step("first_write_after_release", 32'd20, 32'hCAFEF00D);
    read_step("after_release_a4_still0", 32'd4, 32'h0);

    if (exp_q.size() != 0) begin
      miscompares++;
      $error("FAIL scoreboard_leftover: %0d entries remaining, expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_data_memory
